fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised forwarding and hazard unit for the execute stage. It replaces opcode-decoded comparison with a registered scoreboard of in-flight destination writes, one entry per post-EX pipeline stage. Every cycle it produces one priority-resolved forwarding select per EX source operand, plus a load-use/multicycle stall when the needed producer's result is not yet available. It sits beside the EX stage and takes decoded destination and latency information from the ID/EX latch.

## Interface

Parameters:
- DEPTH, 2: post-EX stages that hold results (entry 0 = MEM, entry DEPTH-1 = WB).
- NUM_SRC, 2: EX source operands checked (rs, rt, ...).
- REG_W, 5: register index width; register 0 is never forwarded.
- SEL_W, $clog2(DEPTH+1): select width, derived (local).
- LAT_W, $clog2(DEPTH+1): latency field width, derived (local).

Ports:
- CLK  in  1  pipeline clock.
- RST  in  1  reset, synchronous, active-high.
- advance  in  1  downstream pipeline moves this cycle (0 = global freeze, e.g. memory wait).
- ex_valid  in  1  EX holds a real instruction.
- ex_src  in  NUM_SRC×REG_W  source register indices of the EX instruction.
- ex_src_use  in  NUM_SRC  source n is actually read.
- ex_wr  in  1  EX instruction writes a register.
- ex_dst  in  REG_W  destination index.
- ex_lat  in  LAT_W  entry index at which its result becomes forwardable (0 = ALU result at MEM; 1 = load data at WB).
- ex_flush  in  1  kill the EX instruction (branch/jump squash).
- fwd_sel  out  NUM_SRC×SEL_W  per operand: 0 = register file, k = entry k-1.
- stall  out  1  EX must hold; a bubble enters entry 0.

## Operation

- Each entry holds: valid, wr, dst, lat.
- Match for operand n at entry i: ex_valid, ex_src_use[n], entry valid, entry wr, dst == ex_src[n], dst != 0.
- Priority is youngest first: the lowest matching i wins. fwd_sel[n] = i+1; with no match, fwd_sel[n] = 0.
- Hazard: the winning entry has lat > i, so the data is not ready. stall = OR over operands; the fwd_sel of that operand is a don't-care but is driven to 0.
- An older matching entry never overrides a younger not-ready one.
- Update when advance = 1:
  - entry[i] <= entry[i-1] for i ≥ 1.
  - entry[0] <= EX instruction if ex_valid & !stall & !ex_flush; otherwise a bubble (valid = 0).
- advance = 0: all entries hold. Outputs keep being recomputed from the held state and the current EX inputs.
- ex_flush with stall: a bubble is inserted and the flush wins.
- Reset: all entries valid = 0, wr = 0, dst = 0, lat = 0. Outputs are therefore fwd_sel = 0 and stall = 0.
- RST asserted mid-stall clears the scoreboard, so stall deasserts the next cycle regardless of EX inputs.

## Timing

- fwd_sel and stall are combinational from entry state and EX inputs, valid in the same cycle. There is no output register.
- The scoreboard updates on the rising CLK edge and gives 1-cycle visibility: an instruction in EX at cycle t is matchable as entry 0 at t+1.
- Load-use hazards (lat = 1) resolve after exactly one stall cycle when advance stays high. In general, a producer at entry i with lat L stalls for L−i cycles.
- An entry leaves the scoreboard DEPTH cycles (with advance = 1) after issue. After that the register file supplies the value.

## Configuration

- FWD_STATS_EN defined:
  - adds outputs stat_stall_cnt (32 bits) and stat_fwd_cnt (32 bits).
  - stat_stall_cnt increments on each cycle with stall & advance.
  - stat_fwd_cnt increments once per cycle in which any fwd_sel ≠ 0, ex_valid, and advance.
  - both saturate at all-ones and clear on RST.
- Undefined: these ports and counters do not exist, with zero area.

## Structure

- Shared package cpu_types_pkg gains:
  - fwd_entry_t: a packed struct of valid, wr, dst, lat.
  - constant FWD_DEPTH_DEFAULT = 2.
- Sub-module fwd_match:
  - combinational priority encoder over the DEPTH entries for one operand.
  - outputs sel and not_ready.
  - instantiated NUM_SRC times via generate.

## Test plan

- Back-to-back ALU producer and consumer: add $3 then sub $4, $3, $5 → fwd_sel[0] = 1, stall = 0. One cycle later, an independent instruction reading $3 → fwd_sel[0] = 2.
- Load-use: lw $2 (lat 1) then add $6, $2, $2 → stall = 1 for exactly 1 cycle, with a bubble in entry 0. Next cycle fwd_sel = {2, 2} and stall = 0.
- Youngest wins: writes to $7 in both entry 0 and entry 1 → fwd_sel = 1. A write to $0 with a reader of $0 → fwd_sel = 0.
- Freeze: advance = 0 for 3 cycles during a load-use stall → entries unchanged and stall held. Then advance = 1 → normal release.
- Flush and reset: ex_flush with ex_wr = 1, dst = $9 → no $9 match next cycle. RST during stall → stall = 0 and fwd_sel = 0 next cycle.
- FWD_STATS_EN: 5 stall cycles and 7 forwarding cycles → counters read 5 and 7. A counter preloaded near all-ones saturates at all-ones.

Source files
------------

// File: rtl/fwd_scoreboard_pkg.sv
// Shared CPU types: scoreboard entry layout and default forwarding depth.
// Entry fields are sized for the widest supported configuration; narrower indices are zero-extended.
package cpu_types_pkg;

    localparam int FWD_DEPTH_DEFAULT = 2;
    localparam int FWD_DST_W         = 8;
    localparam int FWD_LAT_W         = 4;

    typedef struct packed {
        logic                 valid;
        logic                 wr;
        logic [FWD_DST_W-1:0] dst;
        logic [FWD_LAT_W-1:0] lat;
    } fwd_entry_t;

endpackage

// File: rtl/fwd_scoreboard_if.sv
// EX-stage to forwarding-scoreboard bundle: decoded EX operands in, selects and stall out.
interface fwd_scoreboard_if
    import cpu_types_pkg::*;
#(
    parameter int DEPTH   = FWD_DEPTH_DEFAULT,
    parameter int NUM_SRC = 2,
    parameter int REG_W   = 5
);
    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam int LAT_W = $clog2(DEPTH + 1);

    logic                              advance;
    logic                              ex_valid;
    logic [NUM_SRC-1:0][REG_W-1:0]     ex_src;
    logic [NUM_SRC-1:0]                ex_src_use;
    logic                              ex_wr;
    logic [REG_W-1:0]                  ex_dst;
    logic [LAT_W-1:0]                  ex_lat;
    logic                              ex_flush;
    logic [NUM_SRC-1:0][SEL_W-1:0]     fwd_sel;
    logic                              stall;

    modport master (
        output advance, ex_valid, ex_src, ex_src_use, ex_wr, ex_dst, ex_lat, ex_flush,
        input  fwd_sel, stall
    );

    modport slave (
        input  advance, ex_valid, ex_src, ex_src_use, ex_wr, ex_dst, ex_lat, ex_flush,
        output fwd_sel, stall
    );

endinterface

// File: rtl/fwd_scoreboard_match.sv
// Youngest-first priority encoder over the scoreboard entries for a single EX source operand.
module fwd_match
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = FWD_DEPTH_DEFAULT,
    parameter int REG_W = 5,
    parameter int SEL_W = 2
) (
    input  fwd_entry_t       entries [DEPTH],
    input  logic             ex_valid,
    input  logic [REG_W-1:0] src,
    input  logic             src_use,
    output logic [SEL_W-1:0] sel,
    output logic             not_ready
);

    logic found;

    // The first hit claims the operand even when its data is late, so an older ready copy never wins.
    always_comb begin
        found     = 1'b0;
        sel       = '0;
        not_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && ex_valid && src_use && (src != '0) &&
                entries[i].valid && entries[i].wr &&
                (entries[i].dst == FWD_DST_W'(src))) begin
                found = 1'b1;
                if (entries[i].lat > FWD_LAT_W'(i)) begin
                    not_ready = 1'b1;
                end else begin
                    sel = SEL_W'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding/hazard scoreboard beside EX: one entry per post-EX stage, shifted on advance.
// Optional FWD_STATS_EN adds saturating stall and forwarding event counters.
module fwd_scoreboard
    import cpu_types_pkg::*;
#(
    parameter int DEPTH   = FWD_DEPTH_DEFAULT,
    parameter int NUM_SRC = 2,
    parameter int REG_W   = 5
) (
    input  logic              CLK,
    input  logic              RST,
    fwd_scoreboard_if.slave   bus
`ifdef FWD_STATS_EN
    ,
    output logic [31:0]       stat_stall_cnt,
    output logic [31:0]       stat_fwd_cnt
`endif
);

    localparam int SEL_W = $clog2(DEPTH + 1);
    localparam int LAT_W = $clog2(DEPTH + 1);

    fwd_entry_t                    entries [DEPTH];
    fwd_entry_t                    incoming;
    logic [NUM_SRC-1:0]            not_ready;
    logic [NUM_SRC-1:0][SEL_W-1:0] sel_vec;
    logic                          stall;
    logic                          issue;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_match
        fwd_match #(
            .DEPTH (DEPTH),
            .REG_W (REG_W),
            .SEL_W (SEL_W)
        ) u_match (
            .entries   (entries),
            .ex_valid  (bus.ex_valid),
            .src       (bus.ex_src[g]),
            .src_use   (bus.ex_src_use[g]),
            .sel       (sel_vec[g]),
            .not_ready (not_ready[g])
        );
    end

    assign stall       = |not_ready;
    assign bus.stall   = stall;
    assign bus.fwd_sel = sel_vec;

    // A stalled or flushed EX instruction must not be recorded; a bubble takes its slot.
    assign issue = bus.ex_valid & ~stall & ~bus.ex_flush;

    always_comb begin
        incoming       = '0;
        incoming.valid = 1'b1;
        incoming.wr    = bus.ex_wr;
        incoming.dst   = FWD_DST_W'(bus.ex_dst);
        incoming.lat   = FWD_LAT_W'(bus.ex_lat);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else if (bus.advance) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                entries[i] <= entries[i-1];
            end
            entries[0] <= issue ? incoming : '0;
        end
    end

`ifdef FWD_STATS_EN
    logic fwd_event;

    assign fwd_event = (|sel_vec) & bus.ex_valid & bus.advance;

    // Counters stick at all-ones rather than wrapping so long runs stay meaningful.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_stall_cnt <= '0;
            stat_fwd_cnt   <= '0;
        end else begin
            if (stall && bus.advance && (stat_stall_cnt != '1)) begin
                stat_stall_cnt <= stat_stall_cnt + 32'd1;
            end
            if (fwd_event && (stat_fwd_cnt != '1)) begin
                stat_fwd_cnt <= stat_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Scoreboard bench for fwd_scoreboard: directed hazard scenarios then random traffic vs. a history model.
module tb_fwd_scoreboard;

    localparam int DEPTH   = 2;
    localparam int NUM_SRC = 2;
    localparam int REG_W   = 5;
    localparam int SEL_W   = $clog2(DEPTH + 1);
    localparam int LAT_W   = $clog2(DEPTH + 1);

    typedef struct {
        bit valid;
        bit wr;
        int dst;
        int lat;
    } producer_t;

    typedef struct {
        logic [NUM_SRC-1:0][SEL_W-1:0] sel;
        logic                          stall;
        int                            cyc;
    } expect_t;

    logic clk;
    logic rst;

    fwd_scoreboard_if #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .REG_W(REG_W)) bus ();

`ifdef FWD_STATS_EN
    logic [31:0] stat_stall_cnt;
    logic [31:0] stat_fwd_cnt;
`endif

    fwd_scoreboard #(.DEPTH(DEPTH), .NUM_SRC(NUM_SRC), .REG_W(REG_W)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
`ifdef FWD_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt),
        .stat_fwd_cnt   (stat_fwd_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // history[k] is the producer issued k+1 advancing cycles ago
    producer_t history [DEPTH];
    expect_t   exp_q [$];
    int        checks = 0;
    int        errors = 0;
    int        cycle  = 0;

    bit        last_rst   = 1'b1;
    bit        last_adv   = 1'b0;
    bit        last_valid = 1'b0;
    bit        last_wr    = 1'b0;
    bit        last_flush = 1'b0;
    int        last_dst   = 0;
    int        last_lat   = 0;
    bit        last_stall = 1'b0;
    bit        last_fwd   = 1'b0;
    longint    model_stall_cnt = 0;
    longint    model_fwd_cnt   = 0;

    task automatic modelClock();
        if (last_rst) begin
            foreach (history[k]) history[k] = '{valid: 1'b0, wr: 1'b0, dst: 0, lat: 0};
            model_stall_cnt = 0;
            model_fwd_cnt   = 0;
        end else begin
            if (last_stall && last_adv) model_stall_cnt++;
            if (last_fwd && last_valid && last_adv) model_fwd_cnt++;
            if (last_adv) begin
                for (int k = DEPTH - 1; k > 0; k--) history[k] = history[k-1];
                if (last_valid && !last_stall && !last_flush)
                    history[0] = '{valid: 1'b1, wr: last_wr, dst: last_dst, lat: last_lat};
                else
                    history[0] = '{valid: 1'b0, wr: 1'b0, dst: 0, lat: 0};
            end
        end
    endtask

    task automatic checkOutput(input expect_t e);
        checks++;
        if (bus.fwd_sel !== e.sel || bus.stall !== e.stall) begin
            errors++;
            $display("[TB] FAIL fwd_out cycle %0d: got sel=%h stall=%b, expected sel=%h stall=%b",
                     e.cyc, bus.fwd_sel, bus.stall, e.sel, e.stall);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit adv, input bit v,
                                 input int s0, input int s1, input bit [1:0] u,
                                 input bit w, input int d, input int l, input bit f);
        expect_t e;
        int      srcs [NUM_SRC];
        bit      found;
        @(posedge clk);
        #1;
        modelClock();
        cycle++;
        rst            = r;
        bus.advance    = adv;
        bus.ex_valid   = v;
        bus.ex_src[0]  = REG_W'(s0);
        bus.ex_src[1]  = REG_W'(s1);
        bus.ex_src_use = u;
        bus.ex_wr      = w;
        bus.ex_dst     = REG_W'(d);
        bus.ex_lat     = LAT_W'(l);
        bus.ex_flush   = f;
        srcs[0] = s0;
        srcs[1] = s1;
        e.sel   = '0;
        e.stall = 1'b0;
        e.cyc   = cycle;
        // A producer issued k+1 cycles ago has its result forwardable once k has reached its latency.
        for (int n = 0; n < NUM_SRC; n++) begin
            found = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                if (!found && v && u[n] && srcs[n] != 0 && history[k].valid &&
                    history[k].wr && history[k].dst == srcs[n]) begin
                    found = 1'b1;
                    if (history[k].lat > k) e.stall = 1'b1;
                    else e.sel[n] = SEL_W'(k + 1);
                end
            end
        end
        exp_q.push_back(e);
        last_rst   = r;
        last_adv   = adv;
        last_valid = v;
        last_wr    = w;
        last_flush = f;
        last_dst   = d;
        last_lat   = l;
        last_stall = e.stall;
        last_fwd   = |e.sel;
    endtask

    task automatic idle();
        applyStimulus(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst            = 1'b1;
        bus.advance    = 1'b0;
        bus.ex_valid   = 1'b0;
        bus.ex_src     = '0;
        bus.ex_src_use = '0;
        bus.ex_wr      = 1'b0;
        bus.ex_dst     = '0;
        bus.ex_lat     = '0;
        bus.ex_flush   = 1'b0;

        repeat (3) applyStimulus(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);

        $display("[TB] back-to-back ALU forwarding");
        applyStimulus(0, 1, 1, 1, 2, 2'b11, 1, 3, 0, 0);
        applyStimulus(0, 1, 1, 3, 5, 2'b11, 1, 4, 0, 0);
        applyStimulus(0, 1, 1, 3, 0, 2'b01, 1, 8, 0, 0);
        idle(); idle();

        $display("[TB] load-use stall");
        applyStimulus(0, 1, 1, 1, 0, 2'b01, 1, 2, 1, 0);
        applyStimulus(0, 1, 1, 2, 2, 2'b11, 1, 6, 0, 0);
        applyStimulus(0, 1, 1, 2, 2, 2'b11, 1, 6, 0, 0);
        idle(); idle();

        $display("[TB] youngest wins and register zero");
        applyStimulus(0, 1, 1, 0, 0, 2'b00, 1, 7, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 2'b00, 1, 7, 0, 0);
        applyStimulus(0, 1, 1, 7, 7, 2'b11, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 2'b00, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0, 2'b11, 0, 0, 0, 0);
        idle(); idle();

        $display("[TB] freeze during load-use stall");
        applyStimulus(0, 1, 1, 1, 0, 2'b01, 1, 2, 1, 0);
        repeat (3) applyStimulus(0, 0, 1, 2, 0, 2'b01, 1, 6, 0, 0);
        applyStimulus(0, 1, 1, 2, 0, 2'b01, 1, 6, 0, 0);
        applyStimulus(0, 1, 1, 2, 0, 2'b01, 1, 6, 0, 0);
        idle(); idle();

        $display("[TB] flush and reset during stall");
        applyStimulus(0, 1, 1, 0, 0, 2'b00, 1, 9, 0, 1);
        applyStimulus(0, 1, 1, 9, 9, 2'b11, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 2'b01, 1, 2, 1, 0);
        applyStimulus(0, 1, 1, 2, 0, 2'b01, 1, 6, 0, 1);
        applyStimulus(1, 1, 1, 2, 0, 2'b01, 1, 6, 0, 0);
        applyStimulus(0, 1, 1, 2, 0, 2'b01, 1, 6, 0, 0);
        idle(); idle();

        $display("[TB] randomized traffic");
        for (int t = 0; t < 600; t++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          ($urandom_range(0, 7) != 0),
                          ($urandom_range(0, 7) != 0),
                          int'($urandom_range(0, 4)),
                          int'($urandom_range(0, 4)),
                          2'($urandom_range(0, 3)),
                          ($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 4)),
                          ($urandom_range(0, 5) == 0) ? 2 : int'($urandom_range(0, 1)),
                          ($urandom_range(0, 9) == 0));
        end
        idle(); idle();

        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

`ifdef FWD_STATS_EN
        checks++;
        if (stat_stall_cnt !== 32'(model_stall_cnt)) begin
            errors++;
            $display("[TB] FAIL stat_stall_cnt: got %0d, expected %0d", stat_stall_cnt, model_stall_cnt);
        end
        checks++;
        if (stat_fwd_cnt !== 32'(model_fwd_cnt)) begin
            errors++;
            $display("[TB] FAIL stat_fwd_cnt: got %0d, expected %0d", stat_fwd_cnt, model_fwd_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
